// File: rtl/regfile_pkg.sv
// Shared widths, constants and the write-request record for the register-file write arbiter.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int ZERO_REG = 0;
    localparam int WCOUNT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first valid at or after i_ptr, wrapping, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_next_ptr
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        o_grant    = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_next_ptr     = PTR_W'((int'(w_idx) + 1) % NUM_REQ);
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port with a registered write stage and commit counter.
// Define WR_BYPASS_EN to add two read ports that forward the write being committed this cycle.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic                          regWrite,
    output logic [ADDR_W-1:0]             write_reg,
    output logic [DATA_W-1:0]             write_data,
    output logic [regfile_pkg::WCOUNT_W-1:0] write_count
`ifdef WR_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]             read_reg_1,
    input  logic [ADDR_W-1:0]             read_reg_2,
    input  logic [DATA_W-1:0]             rf_data_1,
    input  logic [DATA_W-1:0]             rf_data_2,
    output logic [DATA_W-1:0]             read_data_1,
    output logic [DATA_W-1:0]             read_data_2
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CW    = regfile_pkg::WCOUNT_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(regfile_pkg::ZERO_REG);

    logic [PTR_W-1:0]   r_ptr;
    logic               r_write_en;
    logic [ADDR_W-1:0]  r_write_reg;
    logic [DATA_W-1:0]  r_write_data;
    logic [CW-1:0]      r_count;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_transfer;
    logic               w_commit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_valid    (req_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_arb_grant),
        .o_next_ptr (w_next_ptr)
    );

    // Nothing is accepted while reset is asserted, so no request is consumed and then dropped.
    assign w_grant    = rst ? '0 : w_arb_grant;
    assign req_ready  = w_grant;
    assign w_transfer = |w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to the zero register are consumed but never reach the regfile.
    assign w_commit = w_transfer && (w_sel_addr != ZERO_ADDR);

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_ptr        <= '0;
            r_write_en   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_count      <= '0;
        end else begin
            if (w_transfer) begin
                r_ptr <= w_next_ptr;
            end
            r_write_en <= w_commit;
            if (w_commit) begin
                r_write_reg  <= w_sel_addr;
                r_write_data <= w_sel_data;
            end
            // A write counts once the regfile has captured it, i.e. at the end of its regWrite cycle.
            if (r_write_en && (r_count != {CW{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign regWrite    = r_write_en;
    assign write_reg   = r_write_reg;
    assign write_data  = r_write_data;
    assign write_count = r_count;

`ifdef WR_BYPASS_EN
    assign read_data_1 = (r_write_en && (r_write_reg == read_reg_1) && (read_reg_1 != ZERO_ADDR))
                         ? r_write_data : rf_data_1;
    assign read_data_2 = (r_write_en && (r_write_reg == read_reg_2) && (read_reg_2 != ZERO_ADDR))
                         ? r_write_data : rf_data_2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Define WR_BYPASS_EN to also exercise the forwarding read ports.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 2;
    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              regWrite;
    logic [AW-1:0]     write_reg;
    logic [DW-1:0]     write_data;
    logic [15:0]       write_count;
`ifdef WR_BYPASS_EN
    logic [AW-1:0]     read_reg_1, read_reg_2;
    logic [DW-1:0]     rf_data_1, rf_data_2;
    logic [DW-1:0]     read_data_1, read_data_2;
`endif

    regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .regWrite    (regWrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .write_count (write_count)
`ifdef WR_BYPASS_EN
        ,
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .rf_data_1   (rf_data_1),
        .rf_data_2   (rf_data_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the regfile should see, tracked per transaction.
    int      m_ptr;
    bit      m_we;
    wr_req_t m_wr;
    int      m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = AW'(a);
        req_data[i*DW +: DW]  = d;
    endtask

    // Entered just after a rising edge with inputs applied; checks, clocks, updates the model.
    task automatic step(output logic [N-1:0] rdy);
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g       = rst ? -1 : model_winner(req_valid);
        exp_rdy = (g < 0) ? '0 : N'(1 << g);
        rdy     = req_ready;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("regWrite", 64'(regWrite), 64'(m_we));
        check("write_count", 64'(write_count), 64'(m_cnt));
        if (m_we) begin
            check("write_reg", 64'(write_reg), 64'(m_wr.addr));
            check("write_data", 64'(write_data), 64'(m_wr.data));
        end
`ifdef WR_BYPASS_EN
        check("read_data_1", 64'(read_data_1),
              64'((m_we && m_wr.addr == read_reg_1 && read_reg_1 != 0) ? m_wr.data : rf_data_1));
        check("read_data_2", 64'(read_data_2),
              64'((m_we && m_wr.addr == read_reg_2 && read_reg_2 != 0) ? m_wr.data : rf_data_2));
`endif
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_we = 0; m_wr = '0; m_cnt = 0;
        end else begin
            if (m_we && m_cnt < 65535) m_cnt++;
            m_we = 0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (req_addr[g*AW +: AW] != 0) begin
                    m_we      = 1;
                    m_wr.addr = req_addr[g*AW +: AW];
                    m_wr.data = req_data[g*DW +: DW];
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        logic [N-1:0] r;
        rst = 1'b1;
        step(r);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rdy;
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
`ifdef WR_BYPASS_EN
        read_reg_1 = '0; read_reg_2 = '0; rf_data_1 = '0; rf_data_2 = 32'h1234_5678;
`endif
        m_ptr = 0; m_we = 0; m_wr = '0; m_cnt = 0;
        @(posedge clk); #1;

        // 1. Reset held two cycles with both requesters valid.
        set_req(0, 1, 2, 32'd10);
        set_req(1, 1, 3, 32'd20);
        step(rdy);
        check("t1_ready_in_reset", 64'(rdy), 64'(0));
        step(rdy);
        check("t1_ready_in_reset2", 64'(rdy), 64'(0));
        check("t1_regWrite", 64'(regWrite), 64'(0));
        check("t1_count", 64'(write_count), 64'(0));
        check("t1_write_reg", 64'(write_reg), 64'(0));
        check("t1_write_data", 64'(write_data), 64'(0));
        rst = 1'b0;
        step(rdy);
        check("t1_first_grant", 64'(rdy), 64'(2'b01));

        // 2. Single write from requester 0.
        req_valid = '0;
        do_reset();
        set_req(0, 1, 1, 32'd55);
        step(rdy);
        check("t2_ready", 64'(rdy), 64'(2'b01));
        req_valid = '0;
        #1;
        check("t2_regWrite", 64'(regWrite), 64'(1));
        check("t2_write_reg", 64'(write_reg), 64'(1));
        check("t2_write_data", 64'(write_data), 64'(55));
        step(rdy);
        step(rdy);
        check("t2_count", 64'(write_count), 64'(1));

        // 3. Contention: grants must alternate 0,1,0,1.
        do_reset();
        set_req(0, 1, 2, 32'd10);
        set_req(1, 1, 3, 32'd20);
        for (int k = 0; k < 4; k++) begin
            step(rdy);
            check("t3_grant", 64'(rdy), 64'((k % 2) ? 2'b10 : 2'b01));
            if (k > 0) check("t3_regWrite_cont", 64'(regWrite), 64'(1));
        end
        req_valid = '0;
        step(rdy);
        step(rdy);
        check("t3_count", 64'(write_count), 64'(4));

        // 4. Zero-register write: accepted, but no regfile write and no count.
        set_req(1, 1, 0, 32'd99);
        step(rdy);
        check("t4_ready", 64'(rdy), 64'(2'b10));
        req_valid = '0;
        step(rdy);
        check("t4_regWrite", 64'(regWrite), 64'(0));
        check("t4_count", 64'(write_count), 64'(4));

        // 5. Saturation of the commit counter.
        force dut.r_count = 16'hFFFD;
        #1;
        release dut.r_count;
        m_cnt = 'hFFFD;
        set_req(0, 1, 5, 32'hABCD);
        for (int k = 0; k < 4; k++) step(rdy);
        req_valid = '0;
        for (int k = 0; k < 3; k++) step(rdy);
        check("t5_saturated", 64'(write_count), 64'(16'hFFFF));

`ifdef WR_BYPASS_EN
        // 6. Forwarding of the committing write onto read port 1.
        read_reg_1 = 5'd1; rf_data_1 = '0; read_reg_2 = '0;
        set_req(0, 1, 1, 32'd55);
        step(rdy);
        req_valid = '0;
        #1;
        check("t6_bypass_hit", 64'(read_data_1), 64'(55));
        check("t6_zero_passthru", 64'(read_data_2), 64'(rf_data_2));
        step(rdy);
        #1;
        check("t6_bypass_after", 64'(read_data_1), 64'(0));
        @(posedge clk); #1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_we  = 0;
`endif

        // Randomized traffic with withdrawals, zero-register writes and occasional resets.
        rdy = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || rdy[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, 1, ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(31, 1)), $urandom);
                    else
                        req_valid[i] = 1'b0;
                end else if ($urandom_range(9, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rst = ($urandom_range(49, 0) == 0);
`ifdef WR_BYPASS_EN
            read_reg_1 = ($urandom_range(1, 0) == 1) ? m_wr.addr : AW'($urandom);
            read_reg_2 = AW'($urandom_range(3, 0));
            rf_data_1  = $urandom;
            rf_data_2  = $urandom;
`endif
            step(rdy);
            if (rst) rdy = '1;
        end
        rst = 1'b0;
        req_valid = '0;
        step(rdy);
        step(rdy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
